// File: rtl/sw_job_dispatcher_if.sv
// sw_job_dispatcher_if: bundles the job word stream, the SW_core issue/result
// handshakes and the result stream of sw_job_dispatcher.
//   master : dispatcher view (drives s_ready, core_* requests, core_res_ready, m_*)
//   slave  : environment view (word source, SW_core, result sink)
interface sw_job_dispatcher_if #(
    parameter int unsigned REF_MAX_LENGTH       = 128,
    parameter int unsigned READ_MAX_LENGTH      = 128,
    parameter int unsigned DP_SW_SCORE_BITWIDTH = 16
);
    localparam int unsigned RL   = $clog2(REF_MAX_LENGTH) + 1;
    localparam int unsigned QL   = $clog2(READ_MAX_LENGTH) + 1;
    localparam int unsigned RowW = $clog2(READ_MAX_LENGTH);
    localparam int unsigned ColW = $clog2(REF_MAX_LENGTH);

    logic                                   s_valid;
    logic                                   s_ready;
    logic [31:0]                            s_data;

    logic                                   core_ready;
    logic                                   core_valid;
    logic [2*REF_MAX_LENGTH-1:0]            core_seq_ref;
    logic [2*READ_MAX_LENGTH-1:0]           core_seq_read;
    logic [RL-1:0]                          core_ref_len;
    logic [QL-1:0]                          core_read_len;

    logic                                   core_res_valid;
    logic                                   core_res_ready;
    logic signed [DP_SW_SCORE_BITWIDTH-1:0] core_score;
    logic [RowW-1:0]                        core_row;
    logic [ColW-1:0]                        core_col;

    logic                                   m_valid;
    logic                                   m_ready;
    logic signed [DP_SW_SCORE_BITWIDTH-1:0] m_score;
    logic [RowW-1:0]                        m_row;
    logic [ColW-1:0]                        m_col;
    logic [1:0]                             m_err;
    logic [7:0]                             m_job_id;

    modport master (
        input  s_valid, s_data,
        output s_ready,
        input  core_ready,
        output core_valid, core_seq_ref, core_seq_read, core_ref_len, core_read_len,
        input  core_res_valid, core_score, core_row, core_col,
        output core_res_ready,
        input  m_ready,
        output m_valid, m_score, m_row, m_col, m_err, m_job_id
    );

    modport slave (
        output s_valid, s_data,
        input  s_ready,
        output core_ready,
        input  core_valid, core_seq_ref, core_seq_read, core_ref_len, core_read_len,
        output core_res_valid, core_score, core_row, core_col,
        input  core_res_ready,
        output m_ready,
        input  m_valid, m_score, m_row, m_col, m_err, m_job_id
    );
endinterface

// File: rtl/sw_job_dispatcher.sv
// sw_job_dispatcher: takes Smith-Waterman jobs as a 32-bit word stream (one
// header word, then RW reference words and DW read words, 2-bit bases packed
// MSB-first), issues each job to SW_core, and returns score/row/col tagged with
// a wrapping 8-bit job ID and an error code (0 ok, 1 bad length, 2 timeout).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sw_job_dispatcher_if.master (word input, core issue, core
//                result, result output)
// All outputs are registered; one job in flight, no buffering.
module sw_job_dispatcher #(
    parameter int unsigned REF_MAX_LENGTH       = 128,
    parameter int unsigned READ_MAX_LENGTH      = 128,
    parameter int unsigned DP_SW_SCORE_BITWIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES       = 65536
) (
    input logic                 clk,
    input logic                 rst_n,
    sw_job_dispatcher_if.master bus
);
    localparam int unsigned RW   = 2 * REF_MAX_LENGTH / 32;
    localparam int unsigned DW   = 2 * READ_MAX_LENGTH / 32;
    localparam int unsigned RL   = $clog2(REF_MAX_LENGTH) + 1;
    localparam int unsigned QL   = $clog2(READ_MAX_LENGTH) + 1;
    localparam int unsigned RowW = $clog2(READ_MAX_LENGTH);
    localparam int unsigned ColW = $clog2(REF_MAX_LENGTH);
    localparam int unsigned CntW = $clog2((RW > DW) ? RW : DW) + 1;
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrLen     = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    typedef enum logic [2:0] {
        StHdr, StLoadRef, StLoadRead, StIssue, StWaitRes, StOut
    } state_e;

    state_e                                 state_q;
    logic                                   s_ready_q;
    logic                                   core_valid_q;
    logic                                   core_res_ready_q;
    logic [2*REF_MAX_LENGTH-1:0]            ref_q;
    logic [2*READ_MAX_LENGTH-1:0]           read_q;
    logic [RL-1:0]                          ref_len_q;
    logic [QL-1:0]                          read_len_q;
    logic                                   bad_q;
    logic [CntW-1:0]                        word_cnt_q;
    logic [TmoW-1:0]                        tmo_cnt_q;
    logic                                   m_valid_q;
    logic signed [DP_SW_SCORE_BITWIDTH-1:0] m_score_q;
    logic [RowW-1:0]                        m_row_q;
    logic [ColW-1:0]                        m_col_q;
    logic [1:0]                             m_err_q;
    logic [7:0]                             m_job_id_q;

    // Header fields are truncated to the length widths before the range check.
    logic          accept;
    logic [RL-1:0] hdr_ref_len;
    logic [QL-1:0] hdr_read_len;
    logic          hdr_bad;

    assign accept       = bus.s_valid && s_ready_q;
    assign hdr_ref_len  = bus.s_data[16 +: RL];
    assign hdr_read_len = bus.s_data[0 +: QL];
    assign hdr_bad      = (hdr_ref_len == '0) || (hdr_ref_len > RL'(REF_MAX_LENGTH)) ||
                          (hdr_read_len == '0) || (hdr_read_len > QL'(READ_MAX_LENGTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StHdr;
            s_ready_q        <= 1'b0;
            core_valid_q     <= 1'b0;
            core_res_ready_q <= 1'b0;
            ref_q            <= '0;
            read_q           <= '0;
            ref_len_q        <= '0;
            read_len_q       <= '0;
            bad_q            <= 1'b0;
            word_cnt_q       <= '0;
            tmo_cnt_q        <= '0;
            m_valid_q        <= 1'b0;
            m_score_q        <= '0;
            m_row_q          <= '0;
            m_col_q          <= '0;
            m_err_q          <= ErrOk;
            m_job_id_q       <= '0;
        end else begin
            case (state_q)
                StHdr: begin
                    // Also raises s_ready on the first edge after reset release.
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        ref_len_q  <= hdr_ref_len;
                        read_len_q <= hdr_read_len;
                        bad_q      <= hdr_bad;
                        word_cnt_q <= '0;
                        state_q    <= StLoadRef;
                    end
                end
                StLoadRef: begin
                    if (accept) begin
                        // Word k lands at the k-th 32-bit slot from the top.
                        for (int k = 0; k < RW; k++) begin
                            if (word_cnt_q == CntW'(k)) ref_q[(RW-1-k)*32 +: 32] <= bus.s_data;
                        end
                        if (word_cnt_q == CntW'(RW - 1)) begin
                            word_cnt_q <= '0;
                            state_q    <= StLoadRead;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                StLoadRead: begin
                    if (accept) begin
                        for (int k = 0; k < DW; k++) begin
                            if (word_cnt_q == CntW'(k)) read_q[(DW-1-k)*32 +: 32] <= bus.s_data;
                        end
                        if (word_cnt_q == CntW'(DW - 1)) begin
                            word_cnt_q <= '0;
                            s_ready_q  <= 1'b0;
                            if (bad_q) begin
                                m_valid_q <= 1'b1;
                                m_err_q   <= ErrLen;
                                m_score_q <= '0;
                                m_row_q   <= '0;
                                m_col_q   <= '0;
                                state_q   <= StOut;
                            end else begin
                                state_q <= StIssue;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                StIssue: begin
                    // One-cycle pulse; leaving on the edge that drops it.
                    if (core_valid_q) begin
                        core_valid_q     <= 1'b0;
                        core_res_ready_q <= 1'b1;
                        tmo_cnt_q        <= '0;
                        state_q          <= StWaitRes;
                    end else if (bus.core_ready) begin
                        core_valid_q <= 1'b1;
                    end
                end
                StWaitRes: begin
                    if (bus.core_res_valid) begin
                        core_res_ready_q <= 1'b0;
                        m_valid_q        <= 1'b1;
                        m_err_q          <= ErrOk;
                        m_score_q        <= bus.core_score;
                        m_row_q          <= bus.core_row;
                        m_col_q          <= bus.core_col;
                        state_q          <= StOut;
                    end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                        core_res_ready_q <= 1'b0;
                        m_valid_q        <= 1'b1;
                        m_err_q          <= ErrTimeout;
                        m_score_q        <= '0;
                        m_row_q          <= '0;
                        m_col_q          <= '0;
                        state_q          <= StOut;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                StOut: begin
                    if (bus.m_ready) begin
                        m_valid_q  <= 1'b0;
                        m_job_id_q <= m_job_id_q + 8'd1;
                        s_ready_q  <= 1'b1;
                        state_q    <= StHdr;
                    end
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    assign bus.s_ready        = s_ready_q;
    assign bus.core_valid     = core_valid_q;
    assign bus.core_seq_ref   = ref_q;
    assign bus.core_seq_read  = read_q;
    assign bus.core_ref_len   = ref_len_q;
    assign bus.core_read_len  = read_len_q;
    assign bus.core_res_ready = core_res_ready_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_score        = m_score_q;
    assign bus.m_row          = m_row_q;
    assign bus.m_col          = m_col_q;
    assign bus.m_err          = m_err_q;
    assign bus.m_job_id       = m_job_id_q;
endmodule

// File: tb/tb_sw_job_dispatcher.sv
// tb_sw_job_dispatcher: directed and randomized jobs for sw_job_dispatcher,
// checked against a job-level reference model (packing by concatenation,
// header-rule length check, expected result per job, wrapping job counter).
module tb_sw_job_dispatcher;
    localparam int unsigned REF_MAX  = 128;
    localparam int unsigned READ_MAX = 128;
    localparam int unsigned SCW      = 16;
    localparam int unsigned TMO      = 16;
    localparam int unsigned RW       = 2 * REF_MAX / 32;
    localparam int unsigned DW       = 2 * READ_MAX / 32;
    localparam int unsigned RL_MOD   = 1 << ($clog2(REF_MAX) + 1);
    localparam int unsigned QL_MOD   = 1 << ($clog2(READ_MAX) + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sw_job_dispatcher_if #(
        .REF_MAX_LENGTH      (REF_MAX),
        .READ_MAX_LENGTH     (READ_MAX),
        .DP_SW_SCORE_BITWIDTH(SCW)
    ) bus ();

    sw_job_dispatcher #(
        .REF_MAX_LENGTH      (REF_MAX),
        .READ_MAX_LENGTH     (READ_MAX),
        .DP_SW_SCORE_BITWIDTH(SCW),
        .TIMEOUT_CYCLES      (TMO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_id = 0;
    logic [31:0] ref_w  [RW];
    logic [31:0] read_w [DW];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < RW; k++) ref_w[k] = $urandom;
        for (int k = 0; k < DW; k++) read_w[k] = $urandom;
    endtask

    // Offer one word (after random idle gaps) and hold it until accepted.
    task automatic send_word(input logic [31:0] w, input int gap_pct);
        int n;
        logic rdy;
        while (int'($urandom_range(99)) < gap_pct) begin
            bus.s_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        n = 0;
        do begin
            rdy = bus.s_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        bus.s_valid = 1'b0;
        chk("word_accepted", rdy, 1'b1);
    endtask

    // delay < 0: core never answers (timeout path, late answer during OUT).
    task automatic run_job(input logic [31:0] hdr, input int gap, input int stall,
                           input int delay, input int hold, input logic [15:0] sc,
                           input logic [6:0] rw, input logic [6:0] cl);
        logic [255:0] exp_ref, exp_read;
        int           rl, ql, n;
        bit           bad;
        logic [1:0]   e_err;
        logic [15:0]  e_sc;
        logic [6:0]   e_row, e_col;

        rl  = int'(hdr[31:16]) % RL_MOD;
        ql  = int'(hdr[15:0]) % QL_MOD;
        bad = (rl == 0) || (rl > REF_MAX) || (ql == 0) || (ql > READ_MAX);
        exp_ref  = '0;
        exp_read = '0;
        for (int k = 0; k < RW; k++) exp_ref = (exp_ref << 32) | {224'd0, ref_w[k]};
        for (int k = 0; k < DW; k++) exp_read = (exp_read << 32) | {224'd0, read_w[k]};

        bus.core_ready = (stall == 0);
        send_word(hdr, gap);
        for (int k = 0; k < RW; k++) send_word(ref_w[k], gap);
        for (int k = 0; k < DW; k++) send_word(read_w[k], gap);
        chk("s_ready_low_after_load", bus.s_ready, 1'b0);

        if (bad) begin
            e_err = 2'd1; e_sc = '0; e_row = '0; e_col = '0;
            chk("bad_m_valid_next_cycle", bus.m_valid, 1'b1);
            chk("bad_no_core_valid", bus.core_valid, 1'b0);
        end else begin
            chk("issue_core_valid_low", bus.core_valid, 1'b0);
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk("stall_no_core_valid", bus.core_valid, 1'b0);
            end
            bus.core_ready = 1'b1;
            @(posedge clk); #1;
            chk("core_valid_pulse", bus.core_valid, 1'b1);
            chk("core_seq_ref", bus.core_seq_ref, exp_ref);
            chk("core_seq_read", bus.core_seq_read, exp_read);
            chk("core_ref_len", bus.core_ref_len, rl);
            chk("core_read_len", bus.core_read_len, ql);
            @(posedge clk); #1;
            chk("core_valid_one_cycle", bus.core_valid, 1'b0);
            chk("core_res_ready_up", bus.core_res_ready, 1'b1);
            if (delay >= 0) begin
                for (int i = 0; i < delay; i++) begin
                    @(posedge clk); #1;
                end
                bus.core_res_valid = 1'b1;
                bus.core_score     = sc;
                bus.core_row       = rw;
                bus.core_col       = cl;
                @(posedge clk); #1;
                bus.core_res_valid = 1'b0;
                chk("m_valid_after_capture", bus.m_valid, 1'b1);
                chk("core_res_ready_drop", bus.core_res_ready, 1'b0);
                e_err = 2'd0; e_sc = sc; e_row = rw; e_col = cl;
            end else begin
                n = 0;
                while (!bus.m_valid && n < 100) begin
                    @(posedge clk); #1;
                    n++;
                end
                chk("timeout_cycles", n, TMO);
                e_err = 2'd2; e_sc = '0; e_row = '0; e_col = '0;
            end
        end

        chk("m_valid", bus.m_valid, 1'b1);
        chk("m_err", bus.m_err, e_err);
        chk("m_score", $unsigned(bus.m_score), e_sc);
        chk("m_row", bus.m_row, e_row);
        chk("m_col", bus.m_col, e_col);
        chk("m_job_id", bus.m_job_id, exp_id);
        for (int i = 0; i < hold; i++) begin
            // A late core answer during OUT must be ignored.
            bus.core_res_valid = (delay < 0) && !bad && (i == 1);
            bus.core_score     = 16'h7abc;
            bus.core_row       = 7'h55;
            bus.core_col       = 7'h2a;
            @(posedge clk); #1;
            bus.core_res_valid = 1'b0;
            chk("hold_m_valid", bus.m_valid, 1'b1);
            chk("hold_m_err", bus.m_err, e_err);
            chk("hold_m_score", $unsigned(bus.m_score), e_sc);
            chk("hold_m_row_col", {bus.m_row, bus.m_col}, {e_row, e_col});
            chk("hold_m_job_id", bus.m_job_id, exp_id);
            chk("hold_s_ready_low", bus.s_ready, 1'b0);
            chk("hold_core_valid_low", bus.core_valid, 1'b0);
        end
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.m_ready = 1'b0;
        chk("m_valid_drop", bus.m_valid, 1'b0);
        chk("s_ready_next_job", bus.s_ready, 1'b1);
        exp_id = (exp_id + 1) % 256;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, observed hang expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hdr;
        bus.s_valid        = 1'b0;
        bus.s_data         = '0;
        bus.core_ready     = 1'b1;
        bus.core_res_valid = 1'b0;
        bus.core_score     = '0;
        bus.core_row       = '0;
        bus.core_col       = '0;
        bus.m_ready        = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_core_valid", bus.core_valid, 1'b0);
        chk("rst_core_res_ready", bus.core_res_ready, 1'b0);
        chk("rst_m_err_id", {bus.m_err, bus.m_job_id}, 10'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("s_ready_after_reset", bus.s_ready, 1'b1);

        // Nominal job.
        for (int k = 0; k < RW; k++) ref_w[k] = 32'h1B1B1B1B;
        for (int k = 0; k < DW; k++) read_w[k] = 32'hE4E4E4E4;
        run_job(32'h0080_0080, 0, 0, 3, 2, 16'd42, 7'd10, 7'd20);

        // Issue stall plus input gaps and output backpressure.
        fill_random();
        run_job(32'h0040_0021, 30, 20, 5, 5, 16'hff9c, 7'd99, 7'd3);

        // Bad length.
        fill_random();
        run_job(32'h0000_0080, 20, 0, 0, 3, 16'd0, 7'd0, 7'd0);

        // Timeout, with a late answer during OUT.
        fill_random();
        run_job(32'h0010_0010, 0, 0, -1, 4, 16'd0, 7'd0, 7'd0);

        // Truncation boundaries: 0x180 -> 128 ok, 129 bad, 0x100 -> 0 bad.
        fill_random();
        run_job(32'h0180_0080, 0, 0, 1, 1, 16'd7, 7'd127, 7'd127);
        fill_random();
        run_job(32'h0081_0001, 0, 0, 1, 1, 16'd7, 7'd1, 7'd1);
        fill_random();
        run_job(32'h0001_0100, 0, 0, 1, 1, 16'd7, 7'd1, 7'd1);

        // Randomized jobs.
        for (int j = 0; j < 8; j++) begin
            fill_random();
            hdr = {16'($urandom_range(300)), 16'($urandom_range(300))};
            run_job(hdr, int'($urandom_range(40)), int'($urandom_range(3)),
                    ($urandom_range(5) == 0) ? -1 : int'($urandom_range(10)),
                    int'($urandom_range(3)), 16'($urandom), 7'($urandom), 7'($urandom));
        end

        // Reset mid-load after 3 reference words.
        fill_random();
        send_word(32'h0040_0040, 0);
        for (int k = 0; k < 3; k++) send_word(ref_w[k], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_s_ready", bus.s_ready, 1'b0);
        chk("midrst_seq_ref", bus.core_seq_ref, 256'd0);
        chk("midrst_ref_len", bus.core_ref_len, 8'd0);
        chk("midrst_m_job_id", bus.m_job_id, 8'd0);
        chk("midrst_m_valid", bus.m_valid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_s_ready_release", bus.s_ready, 1'b1);
        exp_id = 0;
        fill_random();
        run_job(32'h0080_0080, 10, 0, 2, 1, 16'd1234, 7'd64, 7'd65);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sw_job_dispatcher.md
# sw_job_dispatcher

Upstream driver and result collector for `SW_core`. It accepts Smith-Waterman jobs as a 32-bit word stream. Each job is one header word followed by packed 2-bit-base reference and read words. The block assembles the left-aligned sequence vectors, issues the job to `SW_core` with the valid/ready handshake, captures the core's score/row/column, and returns it on a result stream tagged with a job ID and an error code.

## Interface
Parameters:
- `REF_MAX_LENGTH`, 128: max reference bases. Must be a multiple of 16.
- `READ_MAX_LENGTH`, 128: max read bases. Must be a multiple of 16.
- `DP_SW_SCORE_BITWIDTH`, 16: score width.
- `TIMEOUT_CYCLES`, 65536: max cycles spent in WAIT_RES.

Derived:
- RW = 2·REF_MAX_LENGTH/32 ref words.
- DW = 2·READ_MAX_LENGTH/32 read words.
- RL = clog2(REF_MAX_LENGTH)+1.
- QL = clog2(READ_MAX_LENGTH)+1.

Ports (listed as name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` / `s_ready` in / out 1: input word handshake.
- `s_data` in 32: header or sequence word.
- `core_ready` in 1: `SW_core` `o_ready`.
- `core_valid` out 1: to `SW_core` `i_valid`.
- `core_seq_ref` out 2·REF_MAX_LENGTH: to `i_sequence_ref`.
- `core_seq_read` out 2·READ_MAX_LENGTH: to `i_sequence_read`.
- `core_ref_len` out RL: to `i_seq_ref_length` (1-based).
- `core_read_len` out QL: to `i_seq_read_length` (1-based).
- `core_res_valid` in 1: `SW_core` `o_valid`.
- `core_res_ready` out 1: to `SW_core` `i_ready`.
- `core_score` in DP_SW_SCORE_BITWIDTH, signed: SW score.
- `core_row` in clog2(READ_MAX_LENGTH): row of the best cell.
- `core_col` in clog2(REF_MAX_LENGTH): column of the best cell.
- `m_valid` / `m_ready` out / in 1: result handshake.
- `m_score`, `m_row`, `m_col` out, same widths as the core result: captured result.
- `m_err` out 2: 0 = OK, 1 = bad length, 2 = timeout.
- `m_job_id` out 8: job sequence number, wraps 255→0.

## Operation
States: HDR, LOAD_REF, LOAD_READ, ISSUE, WAIT_RES, OUT.
- **HDR**:
  - Accept the header word: `ref_len` = s_data[31:16] truncated to RL bits, `read_len` = s_data[15:0] truncated to QL bits.
  - Set the bad flag if either length is 0, `ref_len` > REF_MAX_LENGTH, or `read_len` > READ_MAX_LENGTH. Truncation happens first, then the range check.
  - Go to LOAD_REF.
- **LOAD_REF**:
  - Accept exactly RW words. Word k occupies `core_seq_ref`[2·REF_MAX_LENGTH−1−32k -: 32], so packing is MSB-first and left-aligned.
  - Then go to LOAD_READ.
- **LOAD_READ**:
  - Accept exactly DW words into `core_seq_read`, packed the same way.
  - Then go to ISSUE, or to OUT with `m_err`=1 and score/row/col = 0 if the bad flag is set.
  - The word count is fixed regardless of the header lengths.
- **ISSUE**:
  - On the first cycle with `core_ready`=1, register `core_valid`=1 for exactly one cycle.
  - Move to WAIT_RES on the same edge that drops `core_valid`.
- **WAIT_RES**:
  - `core_res_ready`=1.
  - On `core_res_valid`&&`core_res_ready`, capture score/row/col, set `m_err`=0 and go to OUT.
  - The timeout counter clears on entry. If it reaches TIMEOUT_CYCLES with no result, go to OUT with `m_err`=2 and score/row/col = 0.
  - Any later core result is ignored, because `core_res_ready` is low outside WAIT_RES.
- **OUT**:
  - `m_valid`=1 with all `m_*` held stable until `m_ready`.
  - On the handshake, increment `m_job_id` and return to HDR.
- `s_ready`=1 only in HDR, LOAD_REF and LOAD_READ. There is no buffering, so the next job stalls until OUT completes.
- `core_seq_*` and `core_*_len` are held from the load registers until the next job's header or words overwrite them. They must be stable whenever `core_valid`=1.
- Reset (asynchronous, `rst_n`=0) forces, immediately:
  - state HDR;
  - `s_ready`=0 while in reset, then 1 on the first cycle after release;
  - `core_valid`, `core_res_ready`, `m_valid` all 0;
  - all sequence, length and result registers 0;
  - `m_err`=0, `m_job_id`=0, word and timeout counters 0.
- A reset mid-job discards the partial job. The next word after reset is treated as a header.

## Timing
- All outputs are registered.
- Input word accept: one word per cycle when `s_valid`=1. Gaps are allowed.
- Header-to-`core_valid`, with `core_ready` already high: 1 + RW + DW accept cycles, then `core_valid` on the next cycle.
- `core_res_ready` rises the cycle after the `core_valid` pulse.
- `m_valid` rises the cycle after the capture edge (or the timeout edge).
- Bad-length jobs: `m_valid` rises the cycle after the last read word is accepted.
- Results: one per job, in order.

## Test plan
- **Nominal job.** Header 0x0080_0080, ref words 0x1B1B1B1B ×8, read words 0xE4E4E4E4 ×8, core model returns score 42, row 10, col 20.
  - `core_seq_ref`[255:224]=0x1B1B1B1B and `core_ref_len`=128 when `core_valid` pulses.
  - `m_score`=42, `m_row`=10, `m_col`=20, `m_err`=0, `m_job_id`=0.
- **Issue stall.** `core_ready` held low for 20 cycles in ISSUE.
  - No `core_valid` until the cycle after `core_ready` rises.
  - `core_valid` is high for exactly 1 cycle.
- **Backpressure.** Random `s_valid` gaps; `m_ready` low for 5 cycles.
  - `m_*` stable throughout and `s_ready`=0.
  - Second job gets `m_job_id`=1.
- **Bad length.** Header 0x0000_0080.
  - 16 words consumed; `core_valid` never asserted.
  - `m_err`=1, `m_score`=0.
- **Timeout.** `TIMEOUT_CYCLES`=16, core never responds.
  - `m_valid` after 16 cycles in WAIT_RES with `m_err`=2.
  - A late `core_res_valid` does not change `m_*`.
- **Reset mid-load.** `rst_n` low after 3 ref words.
  - Outputs reach reset values without waiting for a clock edge.
  - A fresh full job completes with `m_job_id`=0 and correct packing.
